// File: rtl/name_entry_fsm.sv
// Name entry controller: the user edits NAME_LEN character slots with up/down,
// moves the cursor with left/right, and confirms from the slot past the end.
// Up/down auto-repeat while held; every output comes straight from a register.
module name_entry_fsm #(
   parameter int unsigned NAME_LEN     = 3,
   parameter int unsigned CHAR_SIZE    = 5,
   parameter int unsigned CHAR_MIN     = 0,
   parameter int unsigned CHAR_MAX     = 26,
   parameter int unsigned REPEAT_DELAY = 50,
   parameter int unsigned REPEAT_RATE  = 10
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic                              btn_up,
   input  logic                              btn_down,
   input  logic                              btn_left,
   input  logic                              btn_right,
   output logic [NAME_LEN*CHAR_SIZE-1:0]     name_out,
   output logic [$clog2(NAME_LEN+1)-1:0]     pos,
   output logic                              editing,
   output logic                              done,
   output logic                              done_pulse
);

   localparam int unsigned PW   = $clog2(NAME_LEN + 1);
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned CW   = $clog2(RMAX + 1);

   localparam logic [CHAR_SIZE-1:0] L_MIN   = CHAR_SIZE'(CHAR_MIN);
   localparam logic [CHAR_SIZE-1:0] L_MAX   = CHAR_SIZE'(CHAR_MAX);
   localparam logic [CW-1:0]        L_DELAY = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0]        L_RATE  = CW'(REPEAT_RATE);
   localparam logic [PW-1:0]        L_LAST  = PW'(NAME_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_EDIT, S_CONFIRM, S_DONE} state_t;

   state_t                r_state;
   logic [CHAR_SIZE-1:0]  r_slot [NAME_LEN];
   logic [PW-1:0]         r_pos;
   logic                  r_prev_up, r_prev_down, r_prev_left, r_prev_right;
   // Cycles since the last up/down step; r_*_rep selects the repeat period
   // once the initial delay has elapsed.
   logic [CW-1:0]         r_up_cnt, r_dn_cnt;
   logic                  r_up_rep, r_dn_rep;
   logic                  r_editing, r_done, r_done_pulse;

   logic w_edge_up, w_edge_down, w_edge_left, w_edge_right;
   logic w_up_fire, w_dn_fire;
   logic w_up_run, w_dn_run;

   assign w_edge_up    = btn_up    & ~r_prev_up;
   assign w_edge_down  = btn_down  & ~r_prev_down;
   assign w_edge_left  = btn_left  & ~r_prev_left;
   assign w_edge_right = btn_right & ~r_prev_right;

   // A counter only runs while its button owns the cycle in EDIT; down loses
   // ownership whenever up is pressed.
   assign w_up_run = en & (r_state == S_EDIT) & btn_up;
   assign w_dn_run = en & (r_state == S_EDIT) & btn_down & ~btn_up;

   assign w_up_fire = w_edge_up   | (r_up_cnt == (r_up_rep ? L_RATE : L_DELAY));
   assign w_dn_fire = w_edge_down | (r_dn_cnt == (r_dn_rep ? L_RATE : L_DELAY));

   // State, cursor, character slots, repeat counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_pos        <= '0;
         for (int i = 0; i < NAME_LEN; i++) r_slot[i] <= L_MIN;
         r_prev_up    <= 1'b0;
         r_prev_down  <= 1'b0;
         r_prev_left  <= 1'b0;
         r_prev_right <= 1'b0;
         r_up_cnt     <= '0;
         r_dn_cnt     <= '0;
         r_up_rep     <= 1'b0;
         r_dn_rep     <= 1'b0;
         r_editing    <= 1'b0;
         r_done       <= 1'b0;
         r_done_pulse <= 1'b0;
      end else begin
         r_prev_up    <= btn_up;
         r_prev_down  <= btn_down;
         r_prev_left  <= btn_left;
         r_prev_right <= btn_right;
         r_done_pulse <= 1'b0;

         if (!w_up_run) begin
            r_up_cnt <= '0;
            r_up_rep <= 1'b0;
         end else if (w_up_fire) begin
            r_up_cnt <= CW'(1);
            r_up_rep <= ~w_edge_up;
         end else begin
            r_up_cnt <= r_up_cnt + 1'b1;
         end

         if (!w_dn_run) begin
            r_dn_cnt <= '0;
            r_dn_rep <= 1'b0;
         end else if (w_dn_fire) begin
            r_dn_cnt <= CW'(1);
            r_dn_rep <= ~w_edge_down;
         end else begin
            r_dn_cnt <= r_dn_cnt + 1'b1;
         end

         if (!en) begin
            r_state   <= S_IDLE;
            r_pos     <= '0;
            for (int i = 0; i < NAME_LEN; i++) r_slot[i] <= L_MIN;
            r_editing <= 1'b0;
            r_done    <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  r_state   <= S_EDIT;
                  r_editing <= 1'b1;
               end
               S_EDIT: begin
                  // The highest-priority pressed button owns the cycle, even
                  // when it is only waiting for its next repeat step.
                  if (btn_up) begin
                     if (w_up_fire) begin
                        r_slot[r_pos] <= (r_slot[r_pos] == L_MAX) ? L_MIN
                                                                  : r_slot[r_pos] + 1'b1;
                     end
                  end else if (btn_down) begin
                     if (w_dn_fire) begin
                        r_slot[r_pos] <= (r_slot[r_pos] == L_MIN) ? L_MAX
                                                                  : r_slot[r_pos] - 1'b1;
                     end
                  end else if (btn_left) begin
                     if (w_edge_left && (r_pos != '0)) r_pos <= r_pos - 1'b1;
                  end else if (btn_right) begin
                     if (w_edge_right) begin
                        r_pos <= r_pos + 1'b1;
                        if (r_pos == L_LAST) r_state <= S_CONFIRM;
                     end
                  end
               end
               S_CONFIRM: begin
                  if (w_edge_left) begin
                     r_pos   <= L_LAST;
                     r_state <= S_EDIT;
                  end else if (w_edge_up || w_edge_down || w_edge_right) begin
                     r_state      <= S_DONE;
                     r_editing    <= 1'b0;
                     r_done       <= 1'b1;
                     r_done_pulse <= 1'b1;
                  end
               end
               S_DONE: begin
                  // Name and cursor stay frozen until en drops.
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Pack the slots with slot 0 in the most significant bits.
   always_comb begin
      name_out = '0;
      for (int i = 0; i < NAME_LEN; i++) begin
         name_out[(NAME_LEN-1-i)*CHAR_SIZE +: CHAR_SIZE] = r_slot[i];
      end
   end

   assign pos        = r_pos;
   assign editing    = r_editing;
   assign done       = r_done;
   assign done_pulse = r_done_pulse;

endmodule
